// File: rtl/fma_issue_queue.sv
// fma_issue_queue: input request FIFO, credit-gated issue into registered FMA operands,
// fixed-latency tag pipeline and output result FIFO. FMA_ISSUE_PERF_EN adds perf counters.
module fma_issue_queue #(
   parameter int WIDTH       = 32,
   parameter int TAG_WIDTH   = 4,
   parameter int IN_DEPTH    = 4,
   parameter int OUT_DEPTH   = 4,
   parameter int FMA_LATENCY = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic [WIDTH-1:0]     in_c,
   input  logic [1:0]           in_rnd,
   input  logic [TAG_WIDTH-1:0] in_tag,
   output logic [WIDTH-1:0]     fma_a,
   output logic [WIDTH-1:0]     fma_b,
   output logic [WIDTH-1:0]     fma_c,
   output logic [1:0]           fma_rnd,
   output logic                 fma_issue,
   input  logic [WIDTH-1:0]     fma_result,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_result,
   output logic [TAG_WIDTH-1:0] out_tag,
`ifdef FMA_ISSUE_PERF_EN
   output logic [31:0]          perf_issued,
   output logic [31:0]          perf_stall,
`endif
   output logic                 busy
);
   localparam int IW = $clog2(IN_DEPTH);
   localparam int OW = $clog2(OUT_DEPTH);
   localparam int EW = 3*WIDTH + 2 + TAG_WIDTH;
   localparam int RW = WIDTH + TAG_WIDTH;

   logic [EW-1:0]        in_mem_q [IN_DEPTH];
   logic [RW-1:0]        out_mem_q [OUT_DEPTH];
   logic [IW-1:0]        in_wp_q, in_wp_d, in_rp_q, in_rp_d;
   logic [IW:0]          in_cnt_q, in_cnt_d;
   logic [OW-1:0]        out_wp_q, out_wp_d, out_rp_q, out_rp_d;
   logic [OW:0]          out_cnt_q, out_cnt_d, infl_q, infl_d;
   logic [FMA_LATENCY-1:0] pv_q;
   logic [TAG_WIDTH-1:0] pt_q [FMA_LATENCY];
   logic [EW-1:0]        head;
   logic                 push, issue, capture, pop;

   assign head      = in_mem_q[in_rp_q];
   assign in_ready  = !rst && (in_cnt_q < (IW+1)'(IN_DEPTH));
   assign push      = in_valid && in_ready;
   // Credits cover both in-flight ops and held results, so capture never overflows
   assign issue     = (in_cnt_q != '0) && (({1'b0, infl_q} + {1'b0, out_cnt_q}) < (OW+2)'(OUT_DEPTH));
   assign capture   = pv_q[FMA_LATENCY-1];
   assign out_valid = out_cnt_q != '0;
   assign pop       = out_valid && out_ready;
   assign {out_result, out_tag} = out_mem_q[out_rp_q];
   assign busy      = (in_cnt_q != '0) || (infl_q != '0) || (out_cnt_q != '0);

   always_comb begin
      in_wp_d   = push ? in_wp_q + 1'b1 : in_wp_q;
      in_rp_d   = issue ? in_rp_q + 1'b1 : in_rp_q;
      in_cnt_d  = in_cnt_q + (IW+1)'(push) - (IW+1)'(issue);
      out_wp_d  = capture ? out_wp_q + 1'b1 : out_wp_q;
      out_rp_d  = pop ? out_rp_q + 1'b1 : out_rp_q;
      out_cnt_d = out_cnt_q + (OW+1)'(capture) - (OW+1)'(pop);
      infl_d    = infl_q + (OW+1)'(issue) - (OW+1)'(capture);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_wp_q   <= '0;
         in_rp_q   <= '0;
         in_cnt_q  <= '0;
         out_wp_q  <= '0;
         out_rp_q  <= '0;
         out_cnt_q <= '0;
         infl_q    <= '0;
         pv_q      <= '0;
         fma_a     <= '0;
         fma_b     <= '0;
         fma_c     <= '0;
         fma_rnd   <= 2'b00;
         fma_issue <= 1'b0;
         for (int i = 0; i < FMA_LATENCY; i++) pt_q[i] <= '0;
         for (int i = 0; i < OUT_DEPTH; i++) out_mem_q[i] <= '0;
      end else begin
         in_wp_q   <= in_wp_d;
         in_rp_q   <= in_rp_d;
         in_cnt_q  <= in_cnt_d;
         out_wp_q  <= out_wp_d;
         out_rp_q  <= out_rp_d;
         out_cnt_q <= out_cnt_d;
         infl_q    <= infl_d;
         fma_issue <= issue;
         pv_q[0]   <= issue;
         pt_q[0]   <= head[TAG_WIDTH-1:0];
         for (int i = 1; i < FMA_LATENCY; i++) begin
            pv_q[i] <= pv_q[i-1];
            pt_q[i] <= pt_q[i-1];
         end
         if (push) in_mem_q[in_wp_q] <= {in_a, in_b, in_c, in_rnd, in_tag};
         if (issue) {fma_a, fma_b, fma_c, fma_rnd} <= head[EW-1:TAG_WIDTH];
         if (capture) out_mem_q[out_wp_q] <= {fma_result, pt_q[FMA_LATENCY-1]};
      end
   end

`ifdef FMA_ISSUE_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_issued <= '0;
         perf_stall  <= '0;
      end else begin
         if (issue) perf_issued <= perf_issued + 32'd1;
         if ((in_cnt_q != '0) && !issue) perf_stall <= perf_stall + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_fma_issue_queue.sv
// tb_fma_issue_queue: directed self-checking bench for fma_issue_queue with a stand-in FMA
// datapath; the perf counter scenario runs only when FMA_ISSUE_PERF_EN is defined.
module tb_fma_issue_queue;
   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, fma_issue, out_valid, out_ready, busy;
   logic [31:0] in_a, in_b, in_c, fma_a, fma_b, fma_c, fma_result, out_result;
   logic [1:0]  in_rnd, fma_rnd;
   logic [3:0]  in_tag, out_tag;
`ifdef FMA_ISSUE_PERF_EN
   logic [31:0] perf_issued, perf_stall;
`endif

   int tests = 0, fails = 0;
   int n_issue = 0, iss_run = 0, iss_max = 0, ov_run = 0, ov_max = 0, infl_max = 0;
   logic [3:0]  q_tag [$];
   logic [31:0] q_res [$];

   always #5 clk = ~clk;

   fma_issue_queue dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_rnd(in_rnd), .in_tag(in_tag),
      .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_rnd(fma_rnd), .fma_issue(fma_issue),
      .fma_result(fma_result), .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag),
`ifdef FMA_ISSUE_PERF_EN
      .perf_issued(perf_issued), .perf_stall(perf_stall),
`endif
      .busy(busy)
   );

   function automatic logic [31:0] model(input logic [31:0] a, b, c);
      return (a == 32'h3F800000 && b == 32'h40000000 && c == 32'h3F800000) ? 32'h40400000 : a ^ b ^ c;
   endfunction

   assign fma_result = model(fma_a, fma_b, fma_c);

   task automatic tick();
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         q_tag.push_back(out_tag);
         q_res.push_back(out_result);
      end
      @(posedge clk);
      #1;
      if (fma_issue === 1'b1) begin n_issue++; iss_run++; end else iss_run = 0;
      if (out_valid === 1'b1) ov_run++; else ov_run = 0;
      if (iss_run > iss_max) iss_max = iss_run;
      if (ov_run > ov_max) ov_max = ov_run;
      if (int'(dut.infl_q) > infl_max) infl_max = int'(dut.infl_q);
   endtask

   task automatic push(input logic [31:0] a, b, c, input logic [1:0] r, input logic [3:0] t);
      bit acc = 1'b0;
      in_a = a; in_b = b; in_c = c; in_rnd = r; in_tag = t; in_valid = 1'b1;
      for (int i = 0; i < 64 && !acc; i++) begin
         acc = in_ready;
         tick();
      end
      in_valid = 1'b0;
      tests++;
      if (!acc) begin fails++; $display("FAIL push_accept tag %0d got not accepted exp accepted", t); end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_c = '0; in_rnd = '0; in_tag = '0;
      repeat (3) tick();
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
      tests++; if (fma_issue !== 1'b0) begin fails++; $display("FAIL reset_fma_issue got %b exp 0", fma_issue); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
      tests++; if (fma_a !== 32'h0 || fma_rnd !== 2'b00) begin fails++; $display("FAIL reset_fma_regs got %h/%b exp 0/00", fma_a, fma_rnd); end
      tests++; if (out_result !== 32'h0 || out_tag !== 4'h0) begin fails++; $display("FAIL reset_out_head got %h/%h exp 0/0", out_result, out_tag); end
      rst = 1'b0;
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_in_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_single_op();
      q_tag.delete(); q_res.delete();
      out_ready = 1'b1;
      in_a = 32'h3F800000; in_b = 32'h40000000; in_c = 32'h3F800000; in_rnd = 2'b01; in_tag = 4'd5;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tests++; if (fma_issue !== 1'b0) begin fails++; $display("FAIL single_no_early_issue got %b exp 0", fma_issue); end
      tick();
      tests++; if (fma_issue !== 1'b1) begin fails++; $display("FAIL single_issue got %b exp 1", fma_issue); end
      tests++; if (fma_a !== 32'h3F800000 || fma_b !== 32'h40000000 || fma_c !== 32'h3F800000 || fma_rnd !== 2'b01) begin
         fails++; $display("FAIL single_operands got %h %h %h %b exp 3f800000 40000000 3f800000 01", fma_a, fma_b, fma_c, fma_rnd); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_early_valid got %b exp 0", out_valid); end
      tick();
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_out_valid got %b exp 1", out_valid); end
      tests++; if (out_result !== 32'h40400000 || out_tag !== 4'd5) begin
         fails++; $display("FAIL single_result got %h tag %0d exp 40400000 tag 5", out_result, out_tag); end
      tick();
      tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL single_drained got valid %b busy %b exp 0 0", out_valid, busy); end
   endtask

   task automatic test_backpressure();
      int n0;
      q_tag.delete(); q_res.delete();
      out_ready = 1'b0;
      n0 = n_issue;
      for (int i = 0; i < 8; i++) push(32'h10000000 + i, 32'(i) << 8, 32'(i) << 16, 2'b10, 4'(i));
      repeat (3) tick();
      tests++; if (n_issue - n0 != 4) begin fails++; $display("FAIL bp_issue_count got %0d exp 4", n_issue - n0); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
      tests++; if (dut.in_cnt_q !== 3'd4) begin fails++; $display("FAIL bp_queued got %0d exp 4", dut.in_cnt_q); end
      out_ready = 1'b1;
      for (int i = 0; i < 60 && q_tag.size() < 8; i++) tick();
      tests++; if (q_tag.size() != 8) begin fails++; $display("FAIL bp_out_count got %0d exp 8", q_tag.size()); end
      for (int i = 0; i < 8 && i < q_tag.size(); i++) begin
         tests++;
         if (q_tag[i] !== 4'(i) || q_res[i] !== model(32'h10000000 + i, 32'(i) << 8, 32'(i) << 16)) begin
            fails++; $display("FAIL bp_order idx %0d got tag %0d res %h exp tag %0d res %h", i, q_tag[i], q_res[i], i,
                              model(32'h10000000 + i, 32'(i) << 8, 32'(i) << 16));
         end
      end
      for (int i = 0; i < 20 && busy; i++) tick();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_idle got busy %b exp 0", busy); end
   endtask

   task automatic test_back_to_back();
      q_tag.delete(); q_res.delete();
      out_ready = 1'b1;
      iss_max = 0; ov_max = 0; infl_max = 0;
      for (int i = 0; i < 16; i++) push(32'(i) * 3, 32'(i) << 4, 32'hA5000000, 2'b00, 4'(i));
      repeat (6) tick();
      tests++; if (iss_max != 16) begin fails++; $display("FAIL stream_issue_run got %0d exp 16", iss_max); end
      tests++; if (ov_max != 16) begin fails++; $display("FAIL stream_valid_run got %0d exp 16", ov_max); end
      tests++; if (infl_max > 4) begin fails++; $display("FAIL stream_inflight got %0d exp <=4", infl_max); end
      tests++; if (q_tag.size() != 16) begin fails++; $display("FAIL stream_out_count got %0d exp 16", q_tag.size()); end
      for (int i = 0; i < 16 && i < q_tag.size(); i++) begin
         tests++;
         if (q_tag[i] !== 4'(i) || q_res[i] !== model(32'(i) * 3, 32'(i) << 4, 32'hA5000000)) begin
            fails++; $display("FAIL stream_order idx %0d got tag %0d res %h", i, q_tag[i], q_res[i]);
         end
      end
   endtask

   task automatic test_boundary();
      int n0;
      q_tag.delete(); q_res.delete();
      out_ready = 1'b0;
      n0 = n_issue;
      for (int i = 0; i < 5; i++) push(32'(i), 32'h0, 32'h0, 2'b01, 4'(i));
      repeat (3) tick();
      tests++; if (n_issue - n0 != 4) begin fails++; $display("FAIL bound_credit_limit got %0d exp 4", n_issue - n0); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tests++; if (fma_issue !== 1'b0) begin fails++; $display("FAIL bound_no_issue_on_pop got %b exp 0", fma_issue); end
      tick();
      tests++; if (fma_issue !== 1'b1) begin fails++; $display("FAIL bound_issue_after_pop got %b exp 1", fma_issue); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tests++; if (fma_issue !== 1'b0 || out_valid !== 1'b1) begin
         fails++; $display("FAIL bound_capture_pop got issue %b valid %b exp 0 1", fma_issue, out_valid); end
      tests++; if (dut.out_cnt_q !== 3'd3) begin fails++; $display("FAIL bound_out_count got %0d exp 3", dut.out_cnt_q); end
      out_ready = 1'b1;
      for (int i = 0; i < 20 && q_tag.size() < 5; i++) tick();
      tests++; if (q_tag.size() != 5) begin fails++; $display("FAIL bound_total got %0d exp 5", q_tag.size()); end
      for (int i = 0; i < 5 && i < q_tag.size(); i++) begin
         tests++;
         if (q_tag[i] !== 4'(i) || q_res[i] !== 32'(i)) begin
            fails++; $display("FAIL bound_order idx %0d got tag %0d res %h exp tag %0d res %h", i, q_tag[i], q_res[i], i, i);
         end
      end
   endtask

   task automatic test_mid_reset();
      q_tag.delete(); q_res.delete();
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(32'h55000000 + i, 32'h1, 32'h2, 2'b11, 4'(8 + i));
      repeat (2) tick();
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL mid_full got in_ready %b exp 0", in_ready); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();
      tests++; if (fma_issue !== 1'b1) begin fails++; $display("FAIL mid_inflight_issue got %b exp 1", fma_issue); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         fails++; $display("FAIL mid_reset_state got valid %b busy %b ready %b exp 0 0 1", out_valid, busy, in_ready); end
      q_tag.delete(); q_res.delete();
      out_ready = 1'b1;
      ov_max = 0;
      repeat (6) tick();
      tests++; if (ov_max != 0 || q_tag.size() != 0) begin
         fails++; $display("FAIL mid_stale_result got %0d results exp 0", q_tag.size()); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy got %b exp 0", busy); end
   endtask

`ifdef FMA_ISSUE_PERF_EN
   task automatic test_perf();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) push(32'(i), 32'h7, 32'h9, 2'b00, 4'(i));
      tick();
      out_ready = 1'b1;
      for (int i = 0; i < 30 && busy; i++) tick();
      tests++; if (perf_issued !== 32'd6) begin fails++; $display("FAIL perf_issued got %0d exp 6", perf_issued); end
      tests++; if (perf_stall !== 32'd3) begin fails++; $display("FAIL perf_stall got %0d exp 3", perf_stall); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++; if (perf_issued !== 32'd0 || perf_stall !== 32'd0) begin
         fails++; $display("FAIL perf_reset got %0d/%0d exp 0/0", perf_issued, perf_stall); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_op();
      test_backpressure();
      test_back_to_back();
      test_boundary();
      test_mid_reset();
`ifdef FMA_ISSUE_PERF_EN
      test_perf();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
